// File: rtl/npc_bpred_if.sv
// Fetch/execute interface of the next-PC generator: fetch PC and prediction
// out to IF, resolved control-flow info in from EX, redirect back out.
interface npc_bpred_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic [XLEN-1:0] pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_is_ctrl;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            redirect;

  modport slave (
    input  stall, ex_valid, ex_pc, ex_is_ctrl, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output pc, pred_taken, pred_target, redirect
  );

  modport master (
    output stall, ex_valid, ex_pc, ex_is_ctrl, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pc, pred_taken, pred_target, redirect
  );
endinterface

// File: rtl/npc_bpred.sv
// Next-PC generator: fetch PC register, bimodal 2-bit direction predictor and
// direct-mapped BTB, corrected and trained by the execute stage.
module npc_bpred #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              ENTRIES  = 16
) (
  input  logic          clk,
  input  logic          rst,
  npc_bpred_if.slave    bus
);
  localparam int INDEX_W = $clog2(ENTRIES);
  localparam int TAG_W   = XLEN - INDEX_W - 2;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  typedef logic [INDEX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0]   tag_t;

  // Decoded training action for the entry selected by ex_pc
  typedef struct packed {
    logic inc;
    logic dec;
    logic alloc;
    logic inval;
    logic wr_tgt;
  } upd_t;

  logic [XLEN-1:0]         pc_q, pc_d;
  logic [ENTRIES-1:0]      valid_q;
  logic [ENTRIES-1:0][1:0] cnt_q;
  logic [XLEN-1:0]         target_q [ENTRIES];
  tag_t                    tag_q    [ENTRIES];

  // ---------------- lookup ----------------
  idx_t            f_idx;
  tag_t            f_tag;
  logic            f_hit;
  logic            f_taken;
  logic [XLEN-1:0] f_seq;

  assign f_idx   = pc_q[INDEX_W+1:2];
  assign f_tag   = pc_q[XLEN-1:INDEX_W+2];
  assign f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_taken = f_hit && cnt_q[f_idx][1];
  assign f_seq   = pc_q + FOUR;

  assign bus.pc          = pc_q;
  assign bus.pred_taken  = f_taken;
  assign bus.pred_target = f_taken ? target_q[f_idx] : f_seq;

  // ---------------- resolution ----------------
  logic [XLEN-1:0] ex_seq;
  logic [XLEN-1:0] ex_actual;
  logic [XLEN-1:0] ex_predicted;
  logic            redirect;

  assign ex_seq       = bus.ex_pc + FOUR;
  assign ex_actual    = (bus.ex_is_ctrl && bus.ex_taken) ? bus.ex_target : ex_seq;
  assign ex_predicted = bus.ex_pred_taken ? bus.ex_pred_target : ex_seq;
  assign redirect     = bus.ex_valid && (ex_actual != ex_predicted);
  assign bus.redirect = redirect;

  // ---------------- next PC ----------------
  logic [XLEN-1:0] pc_nxt;

  always_comb begin
    pc_nxt = bus.pred_target;
    if (redirect)       pc_nxt = ex_actual;
    else if (bus.stall) pc_nxt = pc_q;
    pc_d = {pc_nxt[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  // ---------------- training ----------------
  idx_t e_idx;
  tag_t e_tag;
  logic e_hit;
  upd_t upd;

  assign e_idx = bus.ex_pc[INDEX_W+1:2];
  assign e_tag = bus.ex_pc[XLEN-1:INDEX_W+2];
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  always_comb begin
    upd = '0;
    if (bus.ex_valid) begin
      if (bus.ex_is_ctrl) begin
        if (e_hit) begin
          upd.inc    = bus.ex_taken;
          upd.dec    = !bus.ex_taken;
          upd.wr_tgt = bus.ex_taken;
        end else begin
          upd.alloc  = bus.ex_taken;
        end
      end else begin
        // A non-control instruction predicted taken is a BTB alias: drop it
        upd.inval = bus.ex_pred_taken;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q   <= {ENTRIES{2'b01}};
    end else begin
      if (upd.alloc) begin
        valid_q[e_idx] <= 1'b1;
        cnt_q[e_idx]   <= 2'b10;
      end else if (upd.inc && cnt_q[e_idx] != 2'b11) begin
        cnt_q[e_idx] <= cnt_q[e_idx] + 2'b01;
      end else if (upd.dec && cnt_q[e_idx] != 2'b00) begin
        cnt_q[e_idx] <= cnt_q[e_idx] - 2'b01;
      end
      if (upd.inval) valid_q[e_idx] <= 1'b0;
    end
  end

  // Tag/target arrays carry no reset; a write racing reset is suppressed so
  // the discarded update leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && (upd.alloc || upd.wr_tgt)) target_q[e_idx] <= bus.ex_target;
    if (!rst && upd.alloc)                 tag_q[e_idx]    <= e_tag;
  end

endmodule

// File: tb/tb_npc_bpred.sv
// Directed vector bench for npc_bpred: sequential fetch, stall, BTB allocate,
// hysteresis, stall/redirect priority, alias invalidation, wrap, mid-run reset.
module tb_npc_bpred;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  npc_bpred_if #(.XLEN(32)) bus ();

  npc_bpred #(.XLEN(32), .RESET_PC(32'h0), .ENTRIES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_ctrl;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] e_pc;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_redir;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic st, logic ev, logic [31:0] epc, logic ctl,
                              logic tk, logic [31:0] tgt, logic ept, logic [31:0] eptgt,
                              logic [31:0] pc, logic pt, logic [31:0] ptgt, logic rd);
    vec_t v;
    v.stall = st; v.ex_valid = ev; v.ex_pc = epc; v.ex_is_ctrl = ctl;
    v.ex_taken = tk; v.ex_target = tgt; v.ex_pred_taken = ept; v.ex_pred_target = eptgt;
    v.e_pc = pc; v.e_pt = pt; v.e_ptgt = ptgt; v.e_redir = rd;
    return v;
  endfunction

  // Fetch-only cycle: no valid EX instruction
  function automatic vec_t fo(logic st, logic [31:0] pc, logic pt, logic [31:0] ptgt);
    return mk(st, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, pc, pt, ptgt, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.stall          = v.stall;
    bus.ex_valid       = v.ex_valid;
    bus.ex_pc          = v.ex_pc;
    bus.ex_is_ctrl     = v.ex_is_ctrl;
    bus.ex_taken       = v.ex_taken;
    bus.ex_target      = v.ex_target;
    bus.ex_pred_taken  = v.ex_pred_taken;
    bus.ex_pred_target = v.ex_pred_target;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] pc, input logic pt,
                            input logic [31:0] ptgt, input logic rd);
    chk({tag, ".pc"},          bus.pc, pc);
    chk({tag, ".pred_taken"},  {31'b0, bus.pred_taken}, {31'b0, pt});
    chk({tag, ".pred_target"}, bus.pred_target, ptgt);
    chk({tag, ".redirect"},    {31'b0, bus.redirect}, {31'b0, rd});
  endtask

  initial begin
    vec_t idle;
    idle = fo(1'b0, 32'h0, 1'b0, 32'h0);

    // Free run, stall at 8, first taken branch at 0x10 -> 0x04
    vecs.push_back(fo(1'b0, 32'h00, 1'b0, 32'h04));
    vecs.push_back(fo(1'b0, 32'h04, 1'b0, 32'h08));
    vecs.push_back(fo(1'b1, 32'h08, 1'b0, 32'h0C));
    vecs.push_back(fo(1'b1, 32'h08, 1'b0, 32'h0C));
    vecs.push_back(fo(1'b0, 32'h08, 1'b0, 32'h0C));
    vecs.push_back(fo(1'b0, 32'h0C, 1'b0, 32'h10));
    vecs.push_back(mk(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h04, 1'b0, 32'h14, 32'h10, 1'b0, 32'h14, 1'b1));
    vecs.push_back(fo(1'b0, 32'h04, 1'b0, 32'h08));
    vecs.push_back(fo(1'b0, 32'h08, 1'b0, 32'h0C));
    vecs.push_back(fo(1'b0, 32'h0C, 1'b0, 32'h10));
    // Hit now predicted taken; correct resolution, cnt 2->3
    vecs.push_back(mk(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h04, 1'b1, 32'h04, 32'h10, 1'b1, 32'h04, 1'b0));
    // Hysteresis: not-taken, cnt 3->2, redirect to 0x14
    vecs.push_back(mk(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h04, 1'b1, 32'h04, 32'h04, 1'b0, 32'h08, 1'b1));
    // Branch at 0x30 -> 0x10 allocates idx 12, steers fetch back to 0x10
    vecs.push_back(mk(1'b0, 1'b1, 32'h30, 1'b1, 1'b1, 32'h10, 1'b0, 32'h34, 32'h14, 1'b0, 32'h18, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h04, 1'b1, 32'h04, 32'h10, 1'b1, 32'h04, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'h30, 1'b1, 1'b1, 32'h10, 1'b0, 32'h34, 32'h14, 1'b0, 32'h18, 1'b1));
    vecs.push_back(fo(1'b0, 32'h10, 1'b0, 32'h14));
    // Stall together with mispredict: redirect wins
    vecs.push_back(mk(1'b1, 1'b1, 32'h58, 1'b1, 1'b1, 32'h40, 1'b0, 32'h5C, 32'h14, 1'b0, 32'h18, 1'b1));
    // Retrain 0x10 to cnt 2, then alias-invalidate it
    vecs.push_back(mk(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h04, 1'b0, 32'h14, 32'h40, 1'b0, 32'h44, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h00, 1'b1, 32'h04, 32'h04, 1'b0, 32'h08, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'h30, 1'b1, 1'b1, 32'h10, 1'b0, 32'h34, 32'h14, 1'b0, 32'h18, 1'b1));
    vecs.push_back(fo(1'b0, 32'h10, 1'b0, 32'h14));
    // Wrap from 0xFFFF_FFFC to 0
    vecs.push_back(mk(1'b0, 1'b1, 32'h60, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h64, 32'h14, 1'b0, 32'h18, 1'b1));
    vecs.push_back(fo(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000));
    vecs.push_back(fo(1'b0, 32'h00, 1'b0, 32'h04));
    // Misaligned target 0x23 loads as 0x20; idx 8 holds 0x60's tag -> miss
    vecs.push_back(mk(1'b0, 1'b1, 32'h74, 1'b1, 1'b1, 32'h23, 1'b0, 32'h78, 32'h04, 1'b0, 32'h08, 1'b1));
    // ex_valid=0 suppresses redirect despite mismatching EX fields
    vecs.push_back(mk(1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 32'h100, 1'b0, 32'h14, 32'h20, 1'b0, 32'h24, 1'b0));

    // Reset state
    drive(idle);
    #12;
    check_outs("reset", 32'h0, 1'b0, 32'h4, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #3;
      check_outs($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_pt, vecs[i].e_ptgt, vecs[i].e_redir);
      @(posedge clk); #1;
    end

    // Mid-run reset with an allocating update pending at idx 0
    drive(mk(1'b0, 1'b1, 32'h00, 1'b1, 1'b1, 32'h80, 1'b0, 32'h04, 32'h0, 1'b0, 32'h0, 1'b0));
    rst = 1'b1;
    #3;
    chk("midrst.pc_async", bus.pc, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(idle);
    #3;
    check_outs("midrst.after", 32'h0, 1'b0, 32'h4, 1'b0);
    @(posedge clk); #1;
    chk("midrst.next_pc", bus.pc, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
